// File: rtl/trigger_pkg.sv
// Shared types for the multi-stage trigger sequencer.
// Holds sizing localparams, the FSM state enum and the per-stage config record.
package trigger_pkg;

   localparam int TRIG_SAMPLE_WIDTH = 8;
   localparam int TRIG_NUM_STAGES   = 4;
   localparam int TRIG_COUNT_WIDTH  = 16;
   localparam int TRIG_SW =
      (TRIG_NUM_STAGES > 1) ? $clog2(TRIG_NUM_STAGES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      SEEK,
      DONE
   } trig_state_t;

   typedef struct packed {
      logic [TRIG_SAMPLE_WIDTH-1:0] rise;
      logic [TRIG_SAMPLE_WIDTH-1:0] fall;
      logic [TRIG_SAMPLE_WIDTH-1:0] lvl_mask;
      logic [TRIG_SAMPLE_WIDTH-1:0] lvl_val;
      logic [TRIG_COUNT_WIDTH-1:0]  count;
      logic                         last;
   } stage_cfg_t;

endpackage

// File: rtl/trigger_stage_match.sv
// Combinational match of one trigger stage against the current sample.
// Ports: cfg (stage config), data_in/prev (current/previous sample), valid -> stage_hit.
module trigger_stage_match
   import trigger_pkg::*;
(
   input  stage_cfg_t                   cfg,
   input  logic [TRIG_SAMPLE_WIDTH-1:0] data_in,
   input  logic [TRIG_SAMPLE_WIDTH-1:0] prev,
   input  logic                         valid,
   output logic                         stage_hit
);

   logic [TRIG_SAMPLE_WIDTH-1:0] term;

   // Edge selects take priority over the level mask on a channel.
   always_comb begin
      term = '1;
      for (int i = 0; i < TRIG_SAMPLE_WIDTH; i++) begin
         if (cfg.rise[i] && cfg.fall[i])
            term[i] = data_in[i] ^ prev[i];
         else if (cfg.rise[i])
            term[i] = data_in[i] & ~prev[i];
         else if (cfg.fall[i])
            term[i] = ~data_in[i] & prev[i];
         else if (cfg.lvl_mask[i])
            term[i] = (data_in[i] == cfg.lvl_val[i]);
         else
            term[i] = 1'b1;
      end
   end

   assign stage_hit = valid & (&term);

endmodule

// File: rtl/trigger_sequencer.sv
// Multi-stage logic-analyzer trigger: each stage must hit cfg.count+1 times.
// Ports: clock/reset_n, valid/dataIn, arm/abort, cfg_* write, armed/stage_idx/triggered/run.
module trigger_sequencer
   import trigger_pkg::*;
#(
   parameter int SAMPLE_WIDTH = TRIG_SAMPLE_WIDTH,
   parameter int NUM_STAGES   = TRIG_NUM_STAGES,
   parameter int COUNT_WIDTH  = TRIG_COUNT_WIDTH,
   parameter int SW           = TRIG_SW
)
(
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    valid,
   input  logic [SAMPLE_WIDTH-1:0] dataIn,
   input  logic                    arm,
   input  logic                    abort,
   input  logic                    cfg_we,
   input  logic [SW-1:0]           cfg_stage,
   input  logic [SAMPLE_WIDTH-1:0] cfg_rise,
   input  logic [SAMPLE_WIDTH-1:0] cfg_fall,
   input  logic [SAMPLE_WIDTH-1:0] cfg_lvl_mask,
   input  logic [SAMPLE_WIDTH-1:0] cfg_lvl_val,
   input  logic [COUNT_WIDTH-1:0]  cfg_count,
   input  logic                    cfg_last,
   output logic                    armed,
   output logic [SW-1:0]           stage_idx,
   output logic                    triggered,
   output logic                    run
);

   trig_state_t             state_q, state_d;
   logic [SW-1:0]           stage_q, stage_d;
   logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [SAMPLE_WIDTH-1:0] prev_q, prev_d;
   logic                    trig_q, trig_d;
   logic                    run_q, run_d;
   stage_cfg_t              cfg_q [NUM_STAGES];
   stage_cfg_t              cfg_d [NUM_STAGES];

   stage_cfg_t cur_cfg;
   stage_cfg_t new_cfg;
   logic       stage_hit;
   logic       cfg_ok;
   logic       is_final;

   assign cur_cfg = cfg_q[stage_q];

   assign new_cfg = '{rise:     cfg_rise,
                      fall:     cfg_fall,
                      lvl_mask: cfg_lvl_mask,
                      lvl_val:  cfg_lvl_val,
                      count:    cfg_count,
                      last:     cfg_last};

   assign cfg_ok = (int'(cfg_stage) < NUM_STAGES) &&
                   (state_q == IDLE || state_q == DONE);

   assign is_final = cur_cfg.last ||
                     (stage_q == SW'(NUM_STAGES - 1));

   trigger_stage_match u_match (
      .cfg       (cur_cfg),
      .data_in   (dataIn),
      .prev      (prev_q),
      .valid     (valid),
      .stage_hit (stage_hit)
   );

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      cnt_d   = cnt_q;
      prev_d  = prev_q;
      trig_d  = 1'b0;
      run_d   = run_q;
      cfg_d   = cfg_q;
      if (abort) begin
         state_d = IDLE;
         stage_d = '0;
         cnt_d   = '0;
         run_d   = 1'b0;
      end else if (arm) begin
         state_d = PRIME;
         stage_d = '0;
         cnt_d   = '0;
         run_d   = 1'b0;
      end else begin
         if (cfg_we && cfg_ok)
            cfg_d[cfg_stage] = new_cfg;
         unique case (state_q)
            PRIME: begin
               // First sample only seeds prev so edges cannot fire on it.
               if (valid) begin
                  prev_d  = dataIn;
                  state_d = SEEK;
               end
            end
            SEEK: begin
               if (valid) begin
                  prev_d = dataIn;
                  if (stage_hit) begin
                     // >= keeps cnt saturated even if count looks stale.
                     if (cnt_q >= cur_cfg.count) begin
                        cnt_d = '0;
                        if (is_final) begin
                           state_d = DONE;
                           trig_d  = 1'b1;
                           run_d   = 1'b1;
                        end else begin
                           stage_d = stage_q + SW'(1);
                        end
                     end else begin
                        cnt_d = cnt_q + COUNT_WIDTH'(1);
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         stage_q <= '0;
         cnt_q   <= '0;
         prev_q  <= '0;
         trig_q  <= 1'b0;
         run_q   <= 1'b0;
         for (int i = 0; i < NUM_STAGES; i++)
            cfg_q[i] <= '0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         cnt_q   <= cnt_d;
         prev_q  <= prev_d;
         trig_q  <= trig_d;
         run_q   <= run_d;
         cfg_q   <= cfg_d;
      end
   end

   assign armed     = (state_q == PRIME) || (state_q == SEEK);
   assign stage_idx = stage_q;
   assign triggered = trig_q;
   assign run       = run_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer.
// Table-driven vectors plus hand-written arm/abort/config/reset sequences.
module tb_trigger_sequencer;
   import trigger_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        valid;
   logic [7:0]  dataIn;
   logic        arm;
   logic        abort;
   logic        cfg_we;
   logic [1:0]  cfg_stage;
   logic [7:0]  cfg_rise;
   logic [7:0]  cfg_fall;
   logic [7:0]  cfg_lvl_mask;
   logic [7:0]  cfg_lvl_val;
   logic [15:0] cfg_count;
   logic        cfg_last;
   logic        armed;
   logic [1:0]  stage_idx;
   logic        triggered;
   logic        run;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       ar;
      logic       ab;
      logic       e_armed;
      logic [1:0] e_stage;
      logic       e_trig;
      logic       e_run;
   } vec_t;

   vec_t tbl[$];

   always #5 clock = ~clock;

   trigger_sequencer dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .valid        (valid),
      .dataIn       (dataIn),
      .arm          (arm),
      .abort        (abort),
      .cfg_we       (cfg_we),
      .cfg_stage    (cfg_stage),
      .cfg_rise     (cfg_rise),
      .cfg_fall     (cfg_fall),
      .cfg_lvl_mask (cfg_lvl_mask),
      .cfg_lvl_val  (cfg_lvl_val),
      .cfg_count    (cfg_count),
      .cfg_last     (cfg_last),
      .armed        (armed),
      .stage_idx    (stage_idx),
      .triggered    (triggered),
      .run          (run)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic outs(input string nm, input logic a,
                       input logic [1:0] s, input logic t,
                       input logic r);
      chk({nm, ".armed"}, 32'(armed), 32'(a));
      chk({nm, ".stage"}, 32'(stage_idx), 32'(s));
      chk({nm, ".trig"}, 32'(triggered), 32'(t));
      chk({nm, ".run"}, 32'(run), 32'(r));
   endtask

   task automatic drive(input logic v, input logic [7:0] d,
                        input logic ar, input logic ab);
      valid  = v;
      dataIn = d;
      arm    = ar;
      abort  = ab;
      @(posedge clock);
      #1;
      valid = 1'b0;
      arm   = 1'b0;
      abort = 1'b0;
   endtask

   task automatic cfg_write(input logic [1:0] st, input logic [7:0] r,
                            input logic [7:0] f, input logic [7:0] m,
                            input logic [7:0] lv, input logic [15:0] c,
                            input logic l);
      cfg_we       = 1'b1;
      cfg_stage    = st;
      cfg_rise     = r;
      cfg_fall     = f;
      cfg_lvl_mask = m;
      cfg_lvl_val  = lv;
      cfg_count    = c;
      cfg_last     = l;
      @(posedge clock);
      #1;
      cfg_we = 1'b0;
   endtask

   function automatic void add(input logic v, input logic [7:0] d,
                               input logic ar, input logic a,
                               input logic [1:0] s, input logic t,
                               input logic r);
      vec_t x;
      x.v = v; x.d = d; x.ar = ar; x.ab = 1'b0;
      x.e_armed = a; x.e_stage = s; x.e_trig = t; x.e_run = r;
      tbl.push_back(x);
   endfunction

   task automatic run_table(input string nm);
      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].d, tbl[i].ar, tbl[i].ab);
         outs($sformatf("%s[%0d]", nm, i), tbl[i].e_armed,
              tbl[i].e_stage, tbl[i].e_trig, tbl[i].e_run);
      end
      tbl.delete();
   endtask

   initial begin
      reset_n = 1'b0;
      valid = 0; dataIn = 0; arm = 0; abort = 0;
      cfg_we = 0; cfg_stage = 0; cfg_rise = 0; cfg_fall = 0;
      cfg_lvl_mask = 0; cfg_lvl_val = 0; cfg_count = 0; cfg_last = 0;
      repeat (3) @(posedge clock);
      #1;
      outs("reset", 0, 0, 0, 0);
      reset_n = 1'b1;
      drive(1, 8'h01, 0, 0);
      outs("idle_valid", 0, 0, 0, 0);

      // Single rise on ch0; second run arms with ch0 already high.
      cfg_write(0, 8'h01, 0, 0, 0, 0, 1);
      //  v  d     arm a  s  t  r
      add(0, 8'h00, 1, 1, 0, 0, 0);
      add(1, 8'h00, 0, 1, 0, 0, 0);
      add(1, 8'h01, 0, 0, 0, 1, 1);
      add(1, 8'h00, 0, 0, 0, 0, 1);
      add(1, 8'h01, 1, 1, 0, 0, 0);
      add(1, 8'h01, 0, 1, 0, 0, 0);
      add(1, 8'h01, 0, 1, 0, 0, 0);
      add(1, 8'h00, 0, 1, 0, 0, 0);
      add(1, 8'h01, 0, 0, 0, 1, 1);
      run_table("rise");

      // Level ch3 x3 with gaps and invalid samples, then fall ch1.
      cfg_write(0, 0, 0, 8'h08, 8'h08, 2, 0);
      cfg_write(1, 0, 8'h02, 0, 0, 0, 1);
      add(0, 8'h00, 1, 1, 0, 0, 0);
      add(1, 8'h00, 0, 1, 0, 0, 0);
      add(1, 8'h08, 0, 1, 0, 0, 0);
      add(1, 8'h00, 0, 1, 0, 0, 0);
      add(0, 8'h08, 0, 1, 0, 0, 0);
      add(1, 8'h08, 0, 1, 0, 0, 0);
      add(1, 8'h00, 0, 1, 0, 0, 0);
      add(1, 8'h08, 0, 1, 1, 0, 0);
      add(0, 8'h02, 0, 1, 1, 0, 0);
      add(0, 8'h00, 0, 1, 1, 0, 0);
      add(0, 8'h02, 0, 1, 1, 0, 0);
      add(1, 8'h02, 0, 1, 1, 0, 0);
      add(1, 8'h00, 0, 0, 1, 1, 1);
      add(1, 8'h00, 0, 0, 1, 0, 1);
      run_table("two_stage");

      // abort together with arm in SEEK wins.
      drive(0, 8'h00, 1, 0);
      outs("rearm", 1, 0, 0, 0);
      drive(1, 8'h00, 0, 0);
      drive(1, 8'h08, 0, 0);
      outs("seek_cnt", 1, 0, 0, 0);
      drive(1, 8'h08, 1, 1);
      outs("abort_arm", 0, 0, 0, 0);

      // arm in DONE drops run and re-enters PRIME.
      cfg_write(0, 0, 0, 0, 0, 0, 1);
      drive(0, 8'h00, 1, 0);
      drive(1, 8'h00, 0, 0);
      drive(1, 8'h00, 0, 0);
      outs("always_hit", 0, 0, 1, 1);
      drive(0, 8'h00, 1, 0);
      outs("arm_in_done", 1, 0, 0, 0);
      drive(0, 8'h00, 0, 1);
      outs("abort", 0, 0, 0, 0);

      // cfg write while armed is dropped.
      cfg_write(0, 8'h01, 0, 0, 0, 0, 1);
      drive(0, 8'h00, 1, 0);
      drive(1, 8'h00, 0, 0);
      cfg_write(0, 0, 0, 0, 0, 0, 1);
      outs("cfg_in_seek", 1, 0, 0, 0);
      drive(1, 8'h00, 0, 0);
      outs("cfg_dropped", 1, 0, 0, 0);
      drive(1, 8'h01, 0, 0);
      outs("old_cfg_fires", 0, 0, 1, 1);

      // Async reset mid-sequence clears state and config.
      cfg_write(0, 0, 0, 0, 0, 0, 0);
      cfg_write(1, 8'h01, 0, 0, 0, 0, 1);
      drive(0, 8'h00, 1, 0);
      drive(1, 8'h00, 0, 0);
      drive(1, 8'h00, 0, 0);
      outs("pre_reset", 1, 1, 0, 0);
      reset_n = 1'b0;
      #2;
      outs("mid_reset", 0, 0, 0, 0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      drive(0, 8'h00, 1, 0);
      drive(1, 8'h00, 0, 0);
      drive(1, 8'h00, 0, 0);
      outs("cleared_s1", 1, 1, 0, 0);
      drive(1, 8'h00, 0, 0);
      outs("cleared_s2", 1, 2, 0, 0);
      drive(1, 8'h00, 0, 0);
      outs("cleared_s3", 1, 3, 0, 0);
      drive(1, 8'h00, 0, 0);
      outs("cleared_done", 0, 3, 1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
